// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded hold time per grant.
// The registered grant index is decoded to a one-hot grant for the select fabric.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic [7:0] grant,
    output logic       timeout,
    output logic       dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        idx_q, idx_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              hold_limit;
    logic              release_now;
    logic [7:0]        others;

    // First requester after base, scanning base+1 .. base+8; base itself comes last.
    function automatic logic [2:0] rr_search(input logic [2:0] base, input logic [7:0] r);
        logic [2:0] pick;
        logic [2:0] cand;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int off = 1; off <= 8; off++) begin
            cand = base + 3'(off);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign hold_limit  = (cnt_q == HOLD_LAST);
    assign release_now = done | ~req[idx_q] | hold_limit;
    assign others      = req & ~(8'(1) << idx_q);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    idx_d   = rr_search(ptr_q, req);
                    cnt_d   = '0;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                timeout_d = hold_limit;
                if (release_now) begin
                    ptr_d = idx_q;
                    cnt_d = '0;
                    // A sole requester only releases via done or the hold limit, so it always idles.
                    if (|others) begin
                        idx_d = rr_search(idx_q, req);
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (cnt_q != HOLD_SAT) begin
                    cnt_d = cnt_q + HOLD_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= 3'd7;
            idx_q     <= 3'd0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign grant_valid = (state_q == S_GRANT);
    assign grant_idx   = idx_q;
    assign grant       = grant_valid ? (8'(1) << idx_q) : 8'h00;
    assign timeout     = timeout_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: vector table, hand-written corner sequences and a
// randomized run against a cycle-level reference model.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;
    localparam int HOLD_W   = 4;
    localparam int W        = 13;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant;
    logic       timeout;
    logic       dbg_state;

    int n_checks;
    int n_pass;
    logic [W-1:0] exp_q[$];

    // reference model state
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_held;
    bit m_to;

    typedef struct {
        logic [7:0] r;
        logic       d;
        logic       v;
        logic [2:0] idx;
        logic       to;
    } vec_t;
    vec_t vecs[$];

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx),
        .grant      (grant),
        .timeout    (timeout),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] pack_exp(input logic v, input logic [2:0] idx, input logic to);
        logic [7:0] one_hot;
        one_hot = 8'd1 << idx;
        return {v, v ? idx : 3'd0, v ? one_hot : 8'd0, to};
    endfunction

    function automatic logic [W-1:0] actual_word();
        return {grant_valid, grant_valid ? grant_idx : 3'd0, grant, timeout};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // driver: apply inputs for one edge, then compare against the queued expectation
    task automatic cycle(input logic [7:0] r, input logic d, input logic [W-1:0] e, input string name);
        req  = r;
        done = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(name, 32'(actual_word()), 32'(exp_q.pop_front()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 8'h00;
        done  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {grant_valid, grant_idx, grant, timeout, dbg_state}, 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 7;
        m_held  = 0;
        m_to    = 0;
    endtask

    function automatic int model_pick(input int p, input logic [7:0] r);
        for (int k = 1; k <= 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    // One clock edge of the arbiter as described by its rules, counted in held cycles.
    task automatic model_step(input logic [7:0] r, input logic d);
        bit at_limit;
        bit rel;
        logic [7:0] rest;
        if (!m_valid) begin
            m_to = 0;
            if (r != 8'h00) begin
                m_idx   = model_pick(m_ptr, r);
                m_valid = 1;
                m_held  = 1;
            end
        end else begin
            at_limit = (m_held == MAX_HOLD);
            rel      = d || !r[m_idx] || at_limit;
            m_to     = at_limit;
            if (rel) begin
                m_ptr = m_idx;
                rest  = r;
                rest[m_idx] = 1'b0;
                if (rest != 8'h00) begin
                    m_idx  = model_pick(m_ptr, r);
                    m_held = 1;
                end else begin
                    m_valid = 0;
                end
            end else begin
                m_held++;
            end
        end
    endtask

    initial begin
        logic [7:0] r;
        logic       d;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        req      = 8'h00;
        done     = 1'b0;

        // vector table: rotation, sparse rotation, request drops, done on a sole requester
        for (int i = 0; i < 9; i++) vecs.push_back('{8'hFF, 1'b1, 1'b1, 3'(i % 8), 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
        vecs.push_back('{8'h84, 1'b1, 1'b1, 3'd2, 1'b0});
        vecs.push_back('{8'h84, 1'b1, 1'b1, 3'd7, 1'b0});
        vecs.push_back('{8'h84, 1'b1, 1'b1, 3'd2, 1'b0});
        vecs.push_back('{8'h84, 1'b1, 1'b1, 3'd7, 1'b0});
        vecs.push_back('{8'h04, 1'b0, 1'b1, 3'd2, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
        vecs.push_back('{8'h10, 1'b0, 1'b1, 3'd4, 1'b0});
        vecs.push_back('{8'h12, 1'b0, 1'b1, 3'd4, 1'b0});
        vecs.push_back('{8'h02, 1'b0, 1'b1, 3'd1, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 1'b0});
        vecs.push_back('{8'h20, 1'b0, 1'b1, 3'd5, 1'b0});
        vecs.push_back('{8'h20, 1'b1, 1'b0, 3'd0, 1'b0});
        vecs.push_back('{8'h20, 1'b0, 1'b1, 3'd5, 1'b0});
        vecs.push_back('{8'h00, 1'b0, 1'b0, 3'd0, 1'b0});

        do_reset();
        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].d, pack_exp(vecs[i].v, vecs[i].idx, vecs[i].to),
                  $sformatf("vec%0d", i));
        end

        // hold limit between two requesters
        do_reset();
        for (int k = 0; k < MAX_HOLD; k++) cycle(8'h09, 1'b0, pack_exp(1'b1, 3'd0, 1'b0), "hold0");
        cycle(8'h09, 1'b0, pack_exp(1'b1, 3'd3, 1'b1), "hold_to3");
        for (int k = 1; k < MAX_HOLD; k++) cycle(8'h09, 1'b0, pack_exp(1'b1, 3'd3, 1'b0), "hold3");
        cycle(8'h09, 1'b0, pack_exp(1'b1, 3'd0, 1'b1), "hold_to0");

        // sole requester hits the hold limit: one idle cycle, then re-granted
        do_reset();
        for (int k = 0; k < MAX_HOLD; k++) cycle(8'h20, 1'b0, pack_exp(1'b1, 3'd5, 1'b0), "sole5");
        cycle(8'h20, 1'b0, pack_exp(1'b0, 3'd0, 1'b1), "sole_idle");
        cycle(8'h20, 1'b0, pack_exp(1'b1, 3'd5, 1'b0), "sole_regrant");

        // asynchronous reset in the middle of a grant
        do_reset();
        cycle(8'hFF, 1'b0, pack_exp(1'b1, 3'd2 - 3'd2, 1'b0), "pre_rst_grant");
        cycle(8'h7E, 1'b0, pack_exp(1'b1, 3'd1, 1'b0), "pre_rst_handoff");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {grant_valid, grant, timeout}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(8'hFF, 1'b0, pack_exp(1'b1, 3'd0, 1'b0), "post_rst_grant");

        // randomized run against the reference model
        do_reset();
        r = 8'h00;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                r = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1) r = r & 8'($urandom_range(0, 255));
            end
            d = ($urandom_range(0, 7) == 0);
            model_step(r, d);
            cycle(r, d, pack_exp(m_valid, 3'(m_idx), m_to), $sformatf("rand%0d", n));
        end

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
